// File: rtl/vga_capture.sv
// vga_capture: recovers pixel coordinates from a VGA hsync/vsync/RGB stream, checks line and frame
// timing, and streams active pixels once locked. Define VGA_CAPTURE_CRC_EN to add a per-frame CRC-16.

module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        pix_valid,
  output logic [11:0] pix_rgb,
  output logic [11:0] hpos,
  output logic [11:0] vpos,
  output logic        frame_start,
  output logic [11:0] h_meas,
  output logic [11:0] v_meas,
  output logic [7:0]  err_cnt
`ifdef VGA_CAPTURE_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam logic        POL       = (SYNC_POL != 0);
  localparam logic [11:0] CNT_MAX   = 12'hFFF;
  localparam logic [11:0] H_START   = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_END     = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] V_START   = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_END     = 12'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [12:0] H_NOM     = 13'(H_TOTAL);
  localparam logic [12:0] V_NOM     = 13'(V_TOTAL);
  localparam logic [7:0]  GOOD_LAST = 8'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t      state;
  logic [7:0]  good;
  logic        hs_q, vs_q;
  logic [11:0] hcnt, vcnt;

  logic        hs_edge, vs_edge;
  logic        line_err, frame_err, any_err;
  logic        lock_gain, lock_next, in_window;
  logic [12:0] h_len, v_len;
  logic [11:0] hcnt_nxt, vcnt_nxt;

  // Edge detection, measurement and the coordinates this strobe's pixel belongs to.
  always_comb begin
    hs_edge   = pix_en && (hsync == POL) && (hs_q != POL);
    vs_edge   = pix_en && (vsync == POL) && (vs_q != POL);
    h_len     = {1'b0, hcnt} + 13'd1;
    v_len     = {1'b0, vcnt} + 13'd1;
    line_err  = hs_edge && (h_len != H_NOM);
    frame_err = vs_edge && (v_len != V_NOM);
    any_err   = line_err || frame_err;

    if (hs_edge)
      hcnt_nxt = '0;
    else if (hcnt == CNT_MAX)
      hcnt_nxt = hcnt;
    else
      hcnt_nxt = hcnt + 12'd1;

    if (vs_edge)
      vcnt_nxt = '0;
    else if (hs_edge && (vcnt != CNT_MAX))
      vcnt_nxt = vcnt + 12'd1;
    else
      vcnt_nxt = vcnt;

    lock_gain = (state == CHECK) && vs_edge && !any_err && (good == GOOD_LAST);
    lock_next = ((state == LOCKED) && !any_err) || lock_gain;
    in_window = (hcnt_nxt >= H_START) && (hcnt_nxt < H_END) &&
                (vcnt_nxt >= V_START) && (vcnt_nxt < V_END);
  end

  // Lock FSM: errors only count while LOCKED; CHECK silently restarts its good-frame run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEARCH;
      good    <= '0;
      err_cnt <= '0;
      locked  <= 1'b0;
    end else if (pix_en) begin
      locked <= lock_next;
      case (state)
        SEARCH: begin
          if (vs_edge) begin
            state <= CHECK;
            good  <= '0;
          end
        end
        CHECK: begin
          if (any_err) begin
            good <= '0;
          end else if (vs_edge) begin
            if (lock_gain) begin
              state <= LOCKED;
              good  <= '0;
            end else begin
              good <= good + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (any_err) begin
            state <= SEARCH;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // Sync history resets to the asserted level so a reset inside a sync pulse yields no false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q        <= POL;
      vs_q        <= POL;
      hcnt        <= '0;
      vcnt        <= '0;
      h_meas      <= '0;
      v_meas      <= '0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      pix_rgb     <= '0;
      hpos        <= '0;
      vpos        <= '0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hs_q <= hsync;
        vs_q <= vsync;
        hcnt <= hcnt_nxt;
        vcnt <= vcnt_nxt;
        if (hs_edge)
          h_meas <= h_len[12] ? CNT_MAX : h_len[11:0];
        if (vs_edge) begin
          v_meas      <= v_len[12] ? CNT_MAX : v_len[11:0];
          frame_start <= 1'b1;
        end
        if (in_window && lock_next) begin
          pix_valid <= 1'b1;
          pix_rgb   <= rgb;
          hpos      <= hcnt_nxt - H_START;
          vpos      <= vcnt_nxt - V_START;
        end
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [15:0] crc_step12(input logic [15:0] crc_in, input logic [11:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb)
        c = c ^ 16'h1021;
    end
    return c;
  endfunction

  logic [15:0] crc_acc;

  // A frame's CRC is published only if the frame was captured entirely under lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (pix_en) begin
        if (vs_edge) begin
          crc_acc <= 16'hFFFF;
          if (state == LOCKED) begin
            frame_crc <= crc_acc;
            crc_valid <= 1'b1;
          end
        end else if (in_window && lock_next) begin
          crc_acc <= crc_step12(crc_acc, rgb);
        end
      end
    end
  end
`endif

endmodule
